alu_core: RTL and testbench

- 32-bit integer ALU for the processor datapath execute stage.
- Selects one of a fixed set of logic, arithmetic, compare and shift operations on operands A and B, using a 4-bit ALU_operation code from ALU control.
- Result and zero flag are registered: one clock of latency. Zero feeds branch-decision logic.

---
 rtl/alu_core_if.sv | 29 ++
 rtl/alu_core.sv | 79 +++++++
 tb/tb_alu_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// Execute-stage ALU bus: operands and opcode from the datapath, registered
// result and zero flag back to the datapath and branch logic.
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_operation;
  logic [WIDTH-1:0] ALU_result;
  logic             zero;

  // Datapath side: supplies operands/opcode, consumes result and flag
  modport master (
    output A,
    output B,
    output ALU_operation,
    input  ALU_result,
    input  zero
  );

  // ALU side
  modport slave (
    input  A,
    input  B,
    input  ALU_operation,
    output ALU_result,
    output zero
  );
endinterface

// File: rtl/alu_core.sv
// 32-bit integer ALU for the execute stage. One operation per cycle, result
// and zero flag registered with a single clock of latency.
module alu_core #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic signed [WIDTH-1:0] a_s_p0;
  logic signed [WIDTH-1:0] b_s_p0;
  logic        [WIDTH-1:0] a_u_p0;
  logic        [WIDTH-1:0] b_u_p0;
  logic      [SHAMT_W-1:0] shamt_p0;
  logic        [WIDTH-1:0] res_p0;

  logic        [WIDTH-1:0] res_p1;
  logic                    zero_p1;

  // Compare results widen a single flag bit to the full result width.
  function automatic logic [WIDTH-1:0] flag_ext(input logic f);
    flag_ext = {{(WIDTH-1){1'b0}}, f};
  endfunction

  // Stage p0: operand views and combinational next-result
  assign a_u_p0   = bus.A;
  assign b_u_p0   = bus.B;
  assign a_s_p0   = $signed(bus.A);
  assign b_s_p0   = $signed(bus.B);
  assign shamt_p0 = bus.B[SHAMT_W-1:0];

  // Operation select; unknown opcodes produce zero so the flag reads as 1
  always_comb begin
    res_p0 = '0;
    case (bus.ALU_operation)
      OP_AND:  res_p0 = a_u_p0 & b_u_p0;
      OP_OR:   res_p0 = a_u_p0 | b_u_p0;
      OP_ADD:  res_p0 = a_u_p0 + b_u_p0;
      OP_XOR:  res_p0 = a_u_p0 ^ b_u_p0;
      OP_SLL:  res_p0 = a_u_p0 << shamt_p0;
      OP_SRL:  res_p0 = a_u_p0 >> shamt_p0;
      OP_SUB:  res_p0 = a_u_p0 - b_u_p0;
      OP_SLT:  res_p0 = flag_ext(a_s_p0 < b_s_p0);
      OP_SRA:  res_p0 = $unsigned(a_s_p0 >>> shamt_p0);
      OP_SLTU: res_p0 = flag_ext(a_u_p0 < b_u_p0);
      OP_NOR:  res_p0 = ~(a_u_p0 | b_u_p0);
      default: res_p0 = '0;
    endcase
  end

  // Stage p1: capture result and its zero flag every edge; reset clears both
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1  <= '0;
      zero_p1 <= 1'b1;
    end else begin
      res_p1  <= res_p0;
      zero_p1 <= (res_p0 == '0);
    end
  end

  assign bus.ALU_result = res_p1;
  assign bus.zero       = zero_p1;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed cases plus randomized operations against a
// behavioural model built from plain integer arithmetic.
module tb_alu_core;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic on 64-bit values, reduced mod 2^32
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    longint unsigned la;
    longint unsigned lb;
    longint unsigned m;
    int              sa;
    int              sb;
    int unsigned     s;
    la = 64'(a);
    lb = 64'(b);
    m  = 64'h1_0000_0000;
    sa = a;
    sb = b;
    s  = b % 32;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'((la + lb) % m);
      4'd3:  return a ^ b;
      4'd4:  return 32'((la * (64'd1 << s)) % m);
      4'd5:  return 32'(la / (64'd1 << s));
      4'd6:  return 32'((la + m - lb) % m);
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return 32'(sa >>> s);
      4'd9:  return (la < lb) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Present inputs mid-cycle, advance one edge, settle before sampling
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.ALU_operation = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(32'd45, 32'd67, 4'b0010);
      checks++;
      if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h/%b exp=00000000/1", i, bus.ALU_result, bus.zero);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ALU_result !== 32'd112 || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%h/%b exp=00000070/0", bus.ALU_result, bus.zero);
    end
  endtask

  task automatic test_arith();
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    logic [3:0]  ops  [4];
    ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
    exp1 = '{32'd1, 32'd111, 32'd112, 32'hFFFFFFEA};
    exp2 = '{32'd1, 32'd111, 32'd112, 32'd22};
    for (int i = 0; i < 4; i++) begin
      step(32'd45, 32'd67, ops[i]);
      checks++;
      if (bus.ALU_result !== exp1[i] || bus.zero !== 1'b0) begin
        failures++;
        $display("FAIL arith_45_67 op=%b got=%h/%b exp=%h/0", ops[i], bus.ALU_result, bus.zero, exp1[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(32'd67, 32'd45, ops[i]);
      checks++;
      if (bus.ALU_result !== exp2[i] || bus.zero !== 1'b0) begin
        failures++;
        $display("FAIL arith_67_45 op=%b got=%h/%b exp=%h/0", ops[i], bus.ALU_result, bus.zero, exp2[i]);
      end
    end
    step(32'd33, 32'd33, 4'b0110);
    checks++;
    if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_equal got=%h/%b exp=00000000/1", bus.ALU_result, bus.zero);
    end
  endtask

  task automatic test_compare();
    step(32'hFFFFFFFF, 32'd1, 4'b0111);
    checks++;
    if (bus.ALU_result !== 32'd1) begin
      failures++;
      $display("FAIL slt_neg1_1 got=%h exp=00000001", bus.ALU_result);
    end
    step(32'hFFFFFFFF, 32'd1, 4'b1001);
    checks++;
    if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL sltu_max_1 got=%h/%b exp=00000000/1", bus.ALU_result, bus.zero);
    end
    step(32'h80000000, 32'h7FFFFFFF, 4'b0111);
    checks++;
    if (bus.ALU_result !== 32'd1) begin
      failures++;
      $display("FAIL slt_min_max got=%h exp=00000001", bus.ALU_result);
    end
    step(32'h7FFFFFFF, 32'h80000000, 4'b0111);
    checks++;
    if (bus.ALU_result !== 32'd0) begin
      failures++;
      $display("FAIL slt_max_min got=%h exp=00000000", bus.ALU_result);
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops [3];
    logic [31:0] exp [3];
    ops = '{4'b0100, 4'b0101, 4'b1000};
    exp = '{32'h00000010, 32'h08000000, 32'hF8000000};
    for (int i = 0; i < 3; i++) begin
      step(32'h80000001, 32'h00000024, ops[i]);
      checks++;
      if (bus.ALU_result !== exp[i]) begin
        failures++;
        $display("FAIL shift op=%b got=%h exp=%h", ops[i], bus.ALU_result, exp[i]);
      end
    end
    step(32'h9ABCDEF0, 32'hFFFFFFE0, 4'b1000);
    checks++;
    if (bus.ALU_result !== 32'h9ABCDEF0) begin
      failures++;
      $display("FAIL sra_shamt0 got=%h exp=9abcdef0", bus.ALU_result);
    end
  endtask

  task automatic test_edges();
    step(32'hFFFFFFFF, 32'd1, 4'b0010);
    checks++;
    if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got=%h/%b exp=00000000/1", bus.ALU_result, bus.zero);
    end
    step(32'd0, 32'd0, 4'b1100);
    checks++;
    if (bus.ALU_result !== 32'hFFFFFFFF || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL nor_zero got=%h/%b exp=ffffffff/0", bus.ALU_result, bus.zero);
    end
    step(32'h12345678, 32'h9ABCDEF0, 4'b1111);
    checks++;
    if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL undef_op got=%h/%b exp=00000000/1", bus.ALU_result, bus.zero);
    end
  endtask

  task automatic test_mid_reset();
    step(32'd100, 32'd23, 4'b0010);
    checks++;
    if (bus.ALU_result !== 32'd123) begin
      failures++;
      $display("FAIL pre_reset got=%h exp=0000007b", bus.ALU_result);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.A = 32'd5;
    bus.B = 32'd6;
    bus.ALU_operation = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ALU_result !== 32'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b exp=00000000/1", bus.ALU_result, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ALU_result !== 32'd7 || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL post_mid_reset got=%h/%b exp=00000007/0", bus.ALU_result, bus.zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    logic [31:0] specials [6];
    specials = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0000001F};
    for (int i = 0; i < 400; i++) begin
      a  = (($urandom % 4) == 0) ? specials[$urandom % 6] : $urandom;
      b  = (($urandom % 4) == 0) ? specials[$urandom % 6] : $urandom;
      op = 4'($urandom_range(0, 15));
      if (($urandom % 8) == 0) b = a;
      exp = model(a, b, op);
      step(a, b, op);
      checks++;
      if (bus.ALU_result !== exp || bus.zero !== (exp == 32'd0)) begin
        failures++;
        $display("FAIL random i=%0d op=%b a=%h b=%h got=%h/%b exp=%h/%b",
                 i, op, a, b, bus.ALU_result, bus.zero, exp, (exp == 32'd0));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.A    = '0;
    bus.B    = '0;
    bus.ALU_operation = '0;
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_edges();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
